// File: rtl/inst_encoder.sv
// inst_encoder: scatters a scaled signed immediate into the I/S/B/J fields of an instruction word.
// Two-stage valid/ready pipeline with saturating delivery and error counters.
module inst_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        FmtNone,
        FmtI,
        FmtS,
        FmtB,
        FmtJ
    } fmt_e;

    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcJalr  = 7'b1100111;
    localparam logic [6:0] OpcStore = 7'b0100011;
    localparam logic [6:0] OpcBr    = 7'b1100011;
    localparam logic [6:0] OpcJal   = 7'b1101111;

    // Stage 1 state
    logic        r_s1_valid;
    logic [31:0] r_s1_base;
    fmt_e        r_s1_fmt;
    logic [19:0] r_s1_imm;
    logic        r_s1_err;

    // Stage 2 state
    logic        r_s2_valid;
    logic [31:0] r_s2_inst;
    logic        r_s2_err;

    logic [CNT_W-1:0] r_enc_count;
    logic [CNT_W-1:0] r_err_count;

    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_s1_load;
    logic        w_s2_load;
    logic        w_deliver;
    fmt_e        w_fmt;
    logic        w_fits12;
    logic        w_fits20;
    logic        w_err;
    logic [31:0] w_inst;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_s1_load = in_valid && w_s1_adv;
    assign w_s2_load = r_s1_valid && w_s2_adv;
    assign w_deliver = r_s2_valid && out_ready;

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_inst  = r_s2_inst;
    assign out_err   = r_s2_err;
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

    // Format decode and range check on the incoming request
    always_comb begin
        w_fmt = FmtNone;
        case (in_base[6:0])
            OpcOpImm, OpcLoad, OpcJalr: w_fmt = FmtI;
            OpcStore:                   w_fmt = FmtS;
            OpcBr:                      w_fmt = FmtB;
            OpcJal:                     w_fmt = FmtJ;
            default:                    w_fmt = FmtNone;
        endcase

        w_fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
        w_fits20 = (&in_imm[31:19]) || !(|in_imm[31:19]);

        w_err = 1'b0;
        case (w_fmt)
            FmtNone: w_err = |in_imm;
            FmtJ:    w_err = !w_fits20;
            default: w_err = !w_fits12;
        endcase
    end

    // Field scatter from the stage-1 registers
    always_comb begin
        w_inst = r_s1_base;
        case (r_s1_fmt)
            FmtI: begin
                w_inst[31:20] = r_s1_imm[11:0];
            end
            FmtS: begin
                w_inst[31:25] = r_s1_imm[11:5];
                w_inst[11:7]  = r_s1_imm[4:0];
            end
            FmtB: begin
                w_inst[31]    = r_s1_imm[11];
                w_inst[7]     = r_s1_imm[10];
                w_inst[30:25] = r_s1_imm[9:4];
                w_inst[11:8]  = r_s1_imm[3:0];
            end
            FmtJ: begin
                w_inst[31]    = r_s1_imm[19];
                w_inst[19:12] = r_s1_imm[18:11];
                w_inst[20]    = r_s1_imm[10];
                w_inst[30:21] = r_s1_imm[9:0];
            end
            default: begin
                w_inst = r_s1_base;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_base <= '0;
            r_s1_fmt  <= FmtNone;
            r_s1_imm  <= '0;
            r_s1_err  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_base <= in_base;
            r_s1_fmt  <= w_fmt;
            r_s1_imm  <= in_imm[19:0];
            r_s1_err  <= w_err;
        end
    end

    // Output word is held while stalled because stage 2 only loads on advance
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_inst <= '0;
            r_s2_err  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_inst <= w_inst;
            r_s2_err  <= r_s1_err;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_deliver) begin
            if (!(&r_enc_count)) begin
                r_enc_count <= r_enc_count + CNT_W'(1);
            end
            if (r_s2_err && !(&r_err_count)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed checks of inst_encoder formats, pipeline handshake, reset and counters.
// Counter width is reduced so saturation is reachable in a short run.
module tb_inst_encoder;

    localparam int unsigned CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_base = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_inst;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;
    int exp_enc = 0;
    int exp_err = 0;

    inst_encoder #(
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_base  (in_base),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_err  (out_err),
        .enc_count(enc_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference immediate generator (B is the byte offset divided by 2)
    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: imm_gen = {{20{i[31]}}, i[31:20]};
            7'b0100011: imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: imm_gen = {{20{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
            7'b1101111: imm_gen = {{12{i[31]}}, i[31], i[19:12], i[20], i[30:21]};
            default:    imm_gen = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] imm_mask(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: imm_mask = 32'hFFF0_0000;
            7'b0100011, 7'b1100011:             imm_mask = 32'hFE00_0F80;
            7'b1101111:                         imm_mask = 32'hFFFF_F000;
            default:                            imm_mask = 32'h0;
        endcase
    endfunction

    task automatic note_delivery(input logic err);
        if (exp_enc < CNT_MAX) exp_enc++;
        if (err && exp_err < CNT_MAX) exp_err++;
    endtask

    // Pushes one word into an empty pipe and captures it at its output, then completes the handshake.
    task automatic send_one(input logic [31:0] base, input logic [31:0] imm,
                            output logic [31:0] inst, output logic err,
                            output int lat, output logic got);
        in_valid  = 1'b1;
        in_base   = base;
        in_imm    = imm;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got  = out_valid;
        inst = out_inst;
        err  = out_err;
        @(posedge clk); #1;
        if (got) note_delivery(err);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_inst !== 32'h0 || out_err !== 1'b0) begin
            errors++; $display("FAIL reset_out_data: got %h/%b expected 00000000/0", out_inst, out_err);
        end
        checks++;
        if (enc_count !== '0 || err_count !== '0) begin
            errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", enc_count, err_count);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_i_format();
        logic [31:0] inst; logic err; int lat; logic got;
        send_one(32'h0000_0093, 32'hFFFF_FFFF, inst, err, lat, got);
        checks++;
        if (got !== 1'b1 || lat != 1) begin
            errors++; $display("FAIL i_latency: got valid=%b lat=%0d expected valid=1 lat=1", got, lat);
        end
        checks++;
        if (inst !== 32'hFFF0_0093 || err !== 1'b0) begin
            errors++; $display("FAIL i_addi_m1: got %h/%b expected fff00093/0", inst, err);
        end
        checks++;
        if (enc_count !== CNT_W'(1) || out_valid !== 1'b0) begin
            errors++; $display("FAIL i_enc_count: got %0d valid=%b expected 1 valid=0", enc_count, out_valid);
        end
    endtask

    task automatic test_s_b_format();
        logic [31:0] inst; logic err; int lat; logic got;
        send_one(32'h0020_A023, 32'd8, inst, err, lat, got);
        checks++;
        if (got !== 1'b1 || inst !== 32'h0020_A423 || err !== 1'b0) begin
            errors++; $display("FAIL s_sw8: got %h/%b expected 0020a423/0", inst, err);
        end
        checks++;
        if (imm_gen(inst) !== 32'd8) begin
            errors++; $display("FAIL s_roundtrip: got %h expected 00000008", imm_gen(inst));
        end
        send_one(32'h0000_0063, 32'd8, inst, err, lat, got);
        checks++;
        if (got !== 1'b1 || inst !== 32'h0000_0863 || err !== 1'b0) begin
            errors++; $display("FAIL b_beq16: got %h/%b expected 00000863/0", inst, err);
        end
        checks++;
        if (imm_gen(inst) !== 32'd8) begin
            errors++; $display("FAIL b_roundtrip: got %h expected 00000008", imm_gen(inst));
        end
    endtask

    task automatic test_j_and_range();
        logic [31:0] inst; logic err; int lat; logic got;
        send_one(32'h0000_00EF, 32'd1024, inst, err, lat, got);
        checks++;
        if (got !== 1'b1 || inst !== 32'h0010_00EF || err !== 1'b0) begin
            errors++; $display("FAIL j_jal1024: got %h/%b expected 001000ef/0", inst, err);
        end
        send_one(32'h0000_0093, 32'd2048, inst, err, lat, got);
        checks++;
        if (got !== 1'b1 || inst !== 32'h8000_0093 || err !== 1'b1) begin
            errors++; $display("FAIL i_range_err: got %h/%b expected 80000093/1", inst, err);
        end
        checks++;
        if (err_count !== CNT_W'(1) || enc_count !== CNT_W'(exp_enc)) begin
            errors++;
            $display("FAIL err_count_inc: got %0d/%0d expected 1/%0d", err_count, enc_count, exp_enc);
        end
    endtask

    task automatic test_unknown_opcode();
        logic [31:0] inst; logic err; int lat; logic got;
        send_one(32'h0000_0033, 32'd0, inst, err, lat, got);
        checks++;
        if (got !== 1'b1 || inst !== 32'h0000_0033 || err !== 1'b0) begin
            errors++; $display("FAIL unk_zero: got %h/%b expected 00000033/0", inst, err);
        end
        send_one(32'h0000_0033, 32'd5, inst, err, lat, got);
        checks++;
        if (got !== 1'b1 || inst !== 32'h0000_0033 || err !== 1'b1) begin
            errors++; $display("FAIL unk_nonzero: got %h/%b expected 00000033/1", inst, err);
        end
        checks++;
        if (err_count !== CNT_W'(exp_err)) begin
            errors++; $display("FAIL unk_err_count: got %0d expected %0d", err_count, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bases [5];
        logic [31:0] imms [5];
        logic [31:0] expv [5];
        int sent = 0;
        int rcvd = 0;
        int occ = 0;
        int idx;
        logic acc, dlv, exp_rdy;
        for (int k = 0; k < 5; k++) begin
            bases[k] = 32'h0000_0013 | (32'(k + 1) << 7);
            imms[k]  = 32'(k + 1);
            expv[k]  = bases[k] | (32'(k + 1) << 20);
        end
        for (int cyc = 0; cyc < 40 && rcvd < 5; cyc++) begin
            idx = (sent < 5) ? sent : 4;
            in_valid  = (sent < 5);
            in_base   = bases[idx];
            in_imm    = imms[idx];
            out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            exp_rdy = !(occ == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_in_ready cyc%0d: got %b expected %b", cyc, in_ready, exp_rdy);
            end
            dlv = out_valid && out_ready;
            if (dlv) begin
                checks++;
                if (out_inst !== expv[rcvd] || out_err !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_word%0d: got %h/%b expected %h/0", rcvd, out_inst, out_err,
                             expv[rcvd]);
                end
                rcvd++;
                note_delivery(out_err);
            end
            acc = in_valid && in_ready;
            if (acc) sent++;
            occ = occ + int'(acc) - int'(dlv);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd != 5 || sent != 5) begin
            errors++; $display("FAIL bp_totals: got sent=%0d rcvd=%0d expected 5/5", sent, rcvd);
        end
        repeat (2) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (enc_count !== CNT_W'(exp_enc)) begin
            errors++; $display("FAIL bp_enc_count: got %0d expected %0d", enc_count, exp_enc);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_base   = 32'h0000_0093;
        in_imm    = 32'd1;
        @(posedge clk); #1;
        in_imm = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full: got valid=%b ready=%b expected 1/0", out_valid, in_ready);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (enc_count !== '0 || err_count !== '0) begin
            errors++; $display("FAIL mid_rst_counts: got %0d/%0d expected 0/0", enc_count, err_count);
        end
        exp_enc = 0;
        exp_err = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL mid_no_delivery%0d: got out_valid=%b expected 0", k, out_valid);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [6:0] ops [6];
        logic [31:0] base, imm, inst, mask;
        logic err, got;
        int lat, v;
        ops[0] = 7'b0010011; ops[1] = 7'b0000011; ops[2] = 7'b1100111;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        for (int k = 0; k < 16; k++) begin
            base = $urandom;
            base[6:0] = ops[k % 6];
            if (base[6:0] == 7'b1101111) v = int'($urandom_range(0, 1048575)) - 524288;
            else v = int'($urandom_range(0, 4095)) - 2048;
            if (k == 0) v = -2048;
            if (k == 5) v = 524287;
            imm = 32'(v);
            send_one(base, imm, inst, err, lat, got);
            mask = imm_mask(base[6:0]);
            checks++;
            if (got !== 1'b1 || imm_gen(inst) !== imm || err !== 1'b0) begin
                errors++;
                $display("FAIL rt_imm%0d: base %h got imm %h err %b expected %h/0", k, base,
                         imm_gen(inst), err, imm);
            end
            checks++;
            if ((inst & ~mask) !== (base & ~mask)) begin
                errors++; $display("FAIL rt_keep%0d: got %h expected %h", k, inst & ~mask, base & ~mask);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] inst; logic err, got; int lat;
        for (int k = 0; k < 17; k++) begin
            send_one(32'h0000_0093, 32'd2048, inst, err, lat, got);
            checks++;
            if (enc_count !== CNT_W'(exp_enc) || err_count !== CNT_W'(exp_err)) begin
                errors++;
                $display("FAIL sat%0d: got %0d/%0d expected %0d/%0d", k, enc_count, err_count,
                         exp_enc, exp_err);
            end
        end
        checks++;
        if (err_count !== CNT_W'(CNT_MAX) || enc_count !== CNT_W'(CNT_MAX)) begin
            errors++; $display("FAIL sat_hold: got %0d/%0d expected %0d/%0d", enc_count, err_count,
                               CNT_MAX, CNT_MAX);
        end
    endtask

    initial begin
        test_reset();
        test_i_format();
        test_s_b_format();
        test_j_and_range();
        test_unknown_opcode();
        test_back_to_back();
        test_reset_midflight();
        test_round_trip();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Pipelined immediate encoder: the inverse of the core's immediate generator. It takes an instruction word whose immediate fields are don't-care, plus a signed immediate value in the same scaling the immediate generator produces, and scatters the immediate bits into the correct instruction fields for the format implied by the opcode. The round-trip property `ImmGen(inst_encoder(base, imm)) == imm` holds for every in-range value. The block sits in the test/program-loader path, between the instruction stream source and instruction memory, and uses a valid/ready handshake with a two-stage pipeline.

## Interface
Parameters:
- CNT_W, default 16: width of the saturating statistics counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  an upstream request is present.
- in_ready  output  1  the block accepts the request this cycle.
- in_base  input  32  instruction word; opcode, rd, rs1, rs2 and funct bits are kept.
- in_imm  input  32  signed immediate, same scaling as the immediate generator output.
- out_valid  output  1  the encoded word is present.
- out_ready  input  1  downstream accepts the word this cycle.
- out_inst  output  32  encoded instruction.
- out_err  output  1  in_imm was out of range for the format; the word carries the truncated immediate.
- enc_count  output  CNT_W  number of words delivered (handshake completed on the output side), saturating.
- err_count  output  CNT_W  number of delivered words with out_err set, saturating.

## Operation
Format is selected from in_base[6:0]:
- I (0010011, 0000011, 1100111): inst[31:20]=imm[11:0]. Range -2048..2047.
- S (0100011): inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]. Range -2048..2047.
- B (1100011): inst[31]=imm[11], inst[7]=imm[10], inst[30:25]=imm[9:4], inst[11:8]=imm[3:0]. Range -2048..2047. The value is the byte offset divided by 2.
- J (1101111): inst[31]=imm[19], inst[19:12]=imm[18:11], inst[20]=imm[10], inst[30:21]=imm[9:0]. Range -524288..524287.
- Any other opcode: in_base passes through unchanged. out_err=1 if in_imm != 0.

Common rules for every format:
- Bits not listed for the format are copied from in_base.
- Range check: in_imm[31:N-1] must be all zeros or all ones, where N is the field width (12 or 20).
- On a range failure, out_err=1 and the low N bits are still encoded.

Pipeline:
- Stage 1 (S1) registers: in_base, format code (2–3 bits), low 20 bits of imm, err flag.
- Stage 2 (S2) registers: assembled out_inst and out_err. The S2 valid bit drives out_valid.
- The S2 valid bit is set when S1 holds data and S2 advances. S2 advances when S2 is empty or out_ready=1.
- S1 advances under the same condition: S1 empty, or S2 advancing.
- in_ready = !s1_valid | s2_adv. This is combinational from out_ready, giving full throughput with no bubbles.
- While out_valid=1 and out_ready=0, out_inst and out_err stay stable.

Counters:
- enc_count increments on each cycle with out_valid & out_ready.
- err_count increments on the same condition when out_err=1 as well.
- Both counters saturate at 2^CNT_W-1 and hold there.

## Timing
- Reset (rstn low, asynchronous): both valid bits=0, out_valid=0, out_inst=0, out_err=0, enc_count=0, err_count=0.
- in_ready is 1 one cycle after reset release, because both stages are empty.
- Reset asserted mid-operation discards all in-flight words; none are delivered afterwards.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k+1, when both stages are empty ahead of it.
- Throughput: one word per cycle while out_ready=1.
- Backpressure: if out_ready=0 with both stages full, in_ready=0 in the same cycle and nothing is dropped or duplicated.
- Simultaneous events: in one cycle, out_ready=1 with both stages full and in_valid=1 produces one delivery and one acceptance; occupancy is unchanged.
- A counter already at saturation does not wrap when a further delivery occurs.

## Test plan
- Reset, then in_base=0x00000093, in_imm=0xFFFFFFFF (ADDI -1) -> out_inst=0xFFF00093, out_err=0, 2 edges after acceptance; enc_count=1 after the output handshake.
- S and B formats:
  - in_base=0x0020A023, in_imm=8 -> 0x0020A423.
  - in_base=0x00000063, in_imm=8 (16-byte branch) -> 0x00000863.
  - Feeding each output through the immediate generator returns 8.
- J format and range error:
  - in_base=0x000000EF, in_imm=1024 -> 0x001000EF, out_err=0.
  - in_base=0x00000093, in_imm=2048 -> 0x80000093, out_err=1, err_count increments.
- Backpressure: stream 5 words back-to-back with out_ready low for cycles 2–4 -> all 5 delivered in order, none lost or duplicated, in_ready=0 while both stages are full.
- Unknown opcode 0x00000033 with in_imm=0 -> 0x00000033, err=0; with in_imm=5 -> 0x00000033, err=1.
- Assert rstn low while 2 words are in flight -> out_valid falls immediately, counters read 0, and nothing is delivered after release.
- Round-trip sweep: random base/imm pairs within range -> the immediate generator reproduces imm.
